uart_fifo_tx: RTL

- FIFO-reading UART transmitter; the outbound end of a physical UART port.
- Drains a TX FIFO filled by the UART routing matrix (shared tx[8] data bus, per-FIFO cke) and serializes each byte onto a UART line.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Honours a CTS flow-control input between frames.

---
 rtl/uart_fifo_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_tx
// Description : FIFO-reading UART transmitter. Pops one byte at a time from
//               a TX FIFO (1-cycle read latency) and serializes it as
//               start + 8 data bits (LSB first) + optional parity + 1/2 stop.
//               CTS is honoured only between frames.
// Ports       : clk        - master clock, all logic on posedge
//               reset      - synchronous, active-high reset
//               fifo_data  - FIFO read data, valid one clk after fifo_rd
//               fifo_empty - FIFO empty flag
//               fifo_rd    - registered one-clk FIFO read pulse
//               cts        - clear-to-send, gates only the start of a frame
//               tx         - UART line, idles high
//               busy       - high whenever the transmitter is not idle
//               done       - one-clk pulse after the final stop bit
// Parameters  : DIV    - clk cycles per UART bit (>= 1)
//               STOP   - number of stop bits (1 or 2)
//               PARITY - 0 none, 1 odd, 2 even
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_tx #(
    parameter int DIV    = 16,
    parameter int STOP   = 1,
    parameter int PARITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic       cts,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // Divider is at least one bit wide so DIV=1 still has a legal counter.
    localparam int              c_cw        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_div_last  = c_cw'(DIV - 1);
    localparam logic [c_cw-1:0] c_div_one   = c_cw'(1);
    localparam logic [2:0]      c_stop_last = 3'(STOP - 1);

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_fetch = 3'd1;
    localparam logic [2:0] c_s_load  = 3'd2;
    localparam logic [2:0] c_s_start = 3'd3;
    localparam logic [2:0] c_s_data  = 3'd4;
    localparam logic [2:0] c_s_par   = 3'd5;
    localparam logic [2:0] c_s_stop  = 3'd6;

    logic [2:0]      r_state, w_state;
    logic [c_cw-1:0] r_div,   w_div;
    logic [2:0]      r_bit,   w_bit;
    logic [7:0]      r_shift, w_shift;
    logic            r_par,   w_par;
    logic            r_tx,    w_tx;
    logic            r_rd,    w_rd;
    logic            r_busy,  w_busy;
    logic            r_done,  w_done;
    logic            w_bit_end;

    assign w_bit_end = (r_div == c_div_last);

    // Next-state logic. tx is computed one cycle ahead so the line value is
    // registered and changes exactly on bit boundaries.
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_par   = r_par;
        w_tx    = r_tx;
        w_rd    = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            c_s_idle: begin
                w_tx = 1'b1;
                if (!fifo_empty && cts) begin
                    w_state = c_s_fetch;
                    w_rd    = 1'b1;
                end
            end
            c_s_fetch: begin
                // FIFO read data appears during the following (LOAD) cycle.
                w_state = c_s_load;
            end
            c_s_load: begin
                w_shift = fifo_data;
                w_par   = (PARITY == 1) ? ~^fifo_data : ^fifo_data;
                w_div   = '0;
                w_bit   = 3'd0;
                w_tx    = 1'b0;
                w_state = c_s_start;
            end
            c_s_start: begin
                if (w_bit_end) begin
                    w_div   = '0;
                    w_bit   = 3'd0;
                    w_tx    = r_shift[0];
                    w_shift = {1'b0, r_shift[7:1]};
                    w_state = c_s_data;
                end else begin
                    w_div = r_div + c_div_one;
                end
            end
            c_s_data: begin
                if (w_bit_end) begin
                    w_div = '0;
                    if (r_bit == 3'd7) begin
                        w_bit = 3'd0;
                        if (PARITY != 0) begin
                            w_tx    = r_par;
                            w_state = c_s_par;
                        end else begin
                            w_tx    = 1'b1;
                            w_state = c_s_stop;
                        end
                    end else begin
                        w_bit   = r_bit + 3'd1;
                        w_tx    = r_shift[0];
                        w_shift = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_div = r_div + c_div_one;
                end
            end
            c_s_par: begin
                if (w_bit_end) begin
                    w_div   = '0;
                    w_bit   = 3'd0;
                    w_tx    = 1'b1;
                    w_state = c_s_stop;
                end else begin
                    w_div = r_div + c_div_one;
                end
            end
            c_s_stop: begin
                // r_bit counts stop bits here.
                if (w_bit_end) begin
                    w_div = '0;
                    if (r_bit == c_stop_last) begin
                        w_bit   = 3'd0;
                        w_done  = 1'b1;
                        w_state = c_s_idle;
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end else begin
                    w_div = r_div + c_div_one;
                end
            end
            default: begin
                w_state = c_s_idle;
                w_div   = '0;
                w_bit   = 3'd0;
                w_tx    = 1'b1;
            end
        endcase
        w_busy = (w_state != c_s_idle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_s_idle;
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_tx    <= w_tx;
            r_rd    <= w_rd;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign fifo_rd = r_rd;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire
